// File: rtl/orb_pkg.sv
// rtl/orb_pkg.sv - shared types and width helpers for the ORB FAST keypoint path
package orb_pkg;

  function automatic int xw_of(input int x_max);
    return $clog2(x_max) + 1;
  endfunction

  function automatic int yw_of(input int y_max);
    return $clog2(y_max) + 1;
  endfunction

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int KP_XW = xw_of(400);
  localparam int KP_YW = yw_of(400);

  typedef struct packed {
    logic [KP_XW-1:0] x;
    logic [KP_YW-1:0] y;
  } kp_t;

endpackage

// File: rtl/fast_keypoint_reader_kp_fifo2.sv
// rtl/fast_keypoint_reader_kp_fifo2.sv - 2-entry keypoint FIFO with occupancy count
module kp_fifo2
  import orb_pkg::*;
#(
  parameter type T = kp_t
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  T           wdata,
  input  logic       pop,
  output T           rdata,
  output logic [1:0] count
);

  T           mem_q [2];
  T           mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fast_keypoint_reader.sv
// rtl/fast_keypoint_reader.sv - raster-scans the FAST corner map inside the detector
// border and streams one (x,y) per set pixel to the orientation stage
module fast_keypoint_reader
  import orb_pkg::*;
#(
  parameter  int X_MAX  = 400,
  parameter  int Y_MAX  = 400,
  parameter  int BORDER = 3,
  parameter  int CNT_W  = 16,
  localparam int XW     = xw_of(X_MAX),
  localparam int YW     = yw_of(Y_MAX)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [XW-1:0]    img_w,
  input  logic [YW-1:0]    img_h,
  output logic [XW-1:0]    x_addr_fast,
  output logic [YW-1:0]    y_addr_fast,
  output logic             ren_fast,
  input  logic             rdat_fast,
  output logic             kp_valid,
  input  logic             kp_ready,
  output logic [XW-1:0]    kp_x,
  output logic [YW-1:0]    kp_y,
  output logic [CNT_W-1:0] kp_count,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } coord_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    w_q, w_d, x_q, x_d;
  logic [YW-1:0]    h_q, h_d, y_q, y_d;
  logic             inflight_q, inflight_d;
  coord_t           pipe_q, pipe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ren, push, pop;
  logic [1:0]       fifo_count, fifo_next;
  coord_t           fifo_head;
  logic [XW-1:0]    x_last;
  logic [YW-1:0]    y_last;
  logic             too_small;

  assign x_last    = w_q - XW'(BORDER + 1);
  assign y_last    = h_q - YW'(BORDER + 1);
  assign too_small = (img_w <= XW'(2 * BORDER)) || (img_h <= YW'(2 * BORDER));

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    x_d        = x_q;
    y_d        = y_q;
    pipe_d     = pipe_q;
    cnt_d      = cnt_q;
    ren        = 1'b0;
    push       = inflight_q & rdat_fast;
    pop        = (fifo_count != 2'd0) & kp_ready;
    fifo_next  = fifo_count + {1'b0, push} - {1'b0, pop};

    if (pop && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = img_w;
          h_d     = img_h;
          x_d     = XW'(BORDER);
          y_d     = YW'(BORDER);
          cnt_d   = '0;
          state_d = too_small ? DONE : SCAN;
        end
      end
      SCAN: begin
        // At most two keypoints can be owed at once, so the FIFO cannot overflow
        if (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2) begin
          ren    = 1'b1;
          pipe_d = '{x: x_q, y: y_q};
          if (x_q == x_last) begin
            x_d = XW'(BORDER);
            if (y_q == y_last) state_d = DRAIN;
            else               y_d     = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN:   if (fifo_next == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    inflight_d = ren;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      pipe_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      pipe_q     <= pipe_d;
      cnt_q      <= cnt_d;
    end
  end

  kp_fifo2 #(.T(coord_t)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .wdata (pipe_q),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign x_addr_fast = x_q;
  assign y_addr_fast = y_q;
  assign ren_fast    = ren;
  assign kp_valid    = (fifo_count != 2'd0);
  assign kp_x        = fifo_head.x;
  assign kp_y        = fifo_head.y;
  assign kp_count    = cnt_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fast_keypoint_reader.sv
// tb/tb_fast_keypoint_reader.sv - directed bench for fast_keypoint_reader
module tb_fast_keypoint_reader;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 16;
  localparam int B  = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] img_w = '0;
  logic [YW-1:0] img_h = '0;
  logic [XW-1:0] x_addr_fast;
  logic [YW-1:0] y_addr_fast;
  logic          ren_fast;
  logic          rdat_fast = 1'b0;
  logic          kp_valid;
  logic          kp_ready = 1'b0;
  logic [XW-1:0] kp_x;
  logic [YW-1:0] kp_y;
  logic [CW-1:0] kp_count;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fast_keypoint_reader dut (
    .clk(clk), .n_rst(n_rst), .start(start), .img_w(img_w), .img_h(img_h),
    .x_addr_fast(x_addr_fast), .y_addr_fast(y_addr_fast), .ren_fast(ren_fast),
    .rdat_fast(rdat_fast), .kp_valid(kp_valid), .kp_ready(kp_ready),
    .kp_x(kp_x), .kp_y(kp_y), .kp_count(kp_count), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit map [64][64];

  int rd_cnt, rd_bad, done_cnt, done_cyc, stab_bad, first_rd_cyc, start_cyc;
  int first_rx, first_ry, last_rx, last_ry, px, py;
  int tb_w, tb_h;
  int acc_x[$];
  int acc_y[$];
  bit stalled = 1'b0;
  bit ren_l = 1'b0;
  bit rand_ready = 1'b0;
  int ax = 0;
  int ay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    rdat_fast <= (ren_l && ax < 64 && ay < 64) ? map[ay][ax] : 1'b1;

  always @(negedge clk) begin
    if (ren_fast) begin
      if (rd_cnt == 0) begin
        first_rd_cyc = cyc;
        first_rx = int'(x_addr_fast);
        first_ry = int'(y_addr_fast);
      end
      last_rx = int'(x_addr_fast);
      last_ry = int'(y_addr_fast);
      if (int'(x_addr_fast) < B || int'(x_addr_fast) >= tb_w - B ||
          int'(y_addr_fast) < B || int'(y_addr_fast) >= tb_h - B) rd_bad++;
      rd_cnt++;
    end
    ren_l = ren_fast;
    ax = int'(x_addr_fast);
    ay = int'(y_addr_fast);
    if (stalled && (!kp_valid || int'(kp_x) != px || int'(kp_y) != py)) stab_bad++;
    stalled = kp_valid && !kp_ready;
    px = int'(kp_x);
    py = int'(kp_y);
    if (kp_valid && kp_ready) begin
      acc_x.push_back(int'(kp_x));
      acc_y.push_back(int'(kp_y));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) kp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; rd_bad = 0; done_cnt = 0; done_cyc = -1; stab_bad = 0;
    first_rd_cyc = -1; first_rx = -1; first_ry = -1; last_rx = -1; last_ry = -1;
    acc_x.delete();
    acc_y.delete();
  endtask

  task automatic fill_map(input int mode);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        map[y][x] = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w, input int h);
    @(posedge clk);
    #1;
    tb_w = w; tb_h = h;
    img_w = XW'(w); img_h = YW'(h);
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_done_in_time"}, (done_cnt > 0) ? 1 : 0, 1);
    cycles(2);
  endtask

  task automatic check_raster(input string tag);
    int ex[$];
    int ey[$];
    int mis = 0;
    for (int y = B; y < tb_h - B; y++)
      for (int x = B; x < tb_w - B; x++)
        if (map[y][x]) begin
          ex.push_back(x);
          ey.push_back(y);
        end
    chk({tag, "_kp_num"}, acc_x.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      if (i >= acc_x.size() || acc_x[i] != ex[i] || acc_y[i] != ey[i]) mis++;
    chk({tag, "_kp_order"}, mis, 0);
    chk({tag, "_count"}, int'(kp_count), ex.size());
  endtask

  initial begin
    tb_w = 10; tb_h = 10;
    clear_mon();
    fill_map(0);

    cycles(3);
    chk("rst_flags", int'({busy, done, ren_fast, kp_valid}), 0);
    chk("rst_kp_count", int'(kp_count), 0);
    chk("rst_coords", int'(kp_x | x_addr_fast) + int'(kp_y | y_addr_fast), 0);
    n_rst = 1'b1;
    cycles(2);

    // all-zero 10x10 map, plus a start pulse while busy that must be ignored
    kp_ready = 1'b1;
    clear_mon();
    pulse_start(10, 10);
    cycles(3);
    img_w = XW'(20);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_done("zero", 200);
    chk("zero_reads", rd_cnt, 16);
    chk("zero_rd_window", rd_bad, 0);
    chk("zero_first_rd_lat", first_rd_cyc - start_cyc, 1);
    chk("zero_first_addr", first_rx * 100 + first_ry, 303);
    chk("zero_last_addr", last_rx * 100 + last_ry, 606);
    chk("zero_done_lat", done_cyc - start_cyc, 18);
    chk("zero_kp_num", acc_x.size(), 0);
    chk("zero_kp_count", int'(kp_count), 0);
    chk("zero_done_pulses", done_cnt, 1);
    chk("zero_idle", int'(busy), 0);

    // three sparse corners
    fill_map(0);
    map[3][3] = 1'b1;
    map[3][6] = 1'b1;
    map[6][4] = 1'b1;
    clear_mon();
    pulse_start(10, 10);
    wait_done("sparse", 200);
    check_raster("sparse");
    chk("sparse_third_kp", (acc_x.size() == 3) ? acc_x[2] * 100 + acc_y[2] : -1, 406);
    chk("sparse_done_pulses", done_cnt, 1);

    // all-ones with consumer stalled for 20 cycles
    fill_map(1);
    kp_ready = 1'b0;
    clear_mon();
    pulse_start(10, 10);
    cycles(20);
    chk("stall_reads", rd_cnt, 2);
    chk("stall_valid", int'(kp_valid), 1);
    chk("stall_head", int'(kp_x) * 100 + int'(kp_y), 303);
    chk("stall_busy", int'(busy), 1);
    kp_ready = 1'b1;
    wait_done("stall", 400);
    check_raster("stall");
    chk("stall_stable", stab_bad, 0);
    chk("stall_rd_window", rd_bad, 0);

    // image too small for the border; start held into the DONE cycle
    clear_mon();
    @(posedge clk);
    #1;
    tb_w = 6; tb_h = 10;
    img_w = XW'(6); img_h = YW'(10);
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    cycles(2);
    start = 1'b0;
    cycles(5);
    chk("small_reads", rd_cnt, 0);
    chk("small_done_lat", done_cyc - start_cyc, 1);
    chk("small_done_pulses", done_cnt, 1);
    chk("small_kp_count", int'(kp_count), 0);
    chk("small_busy", int'(busy), 0);

    // random map with a random consumer
    fill_map(2);
    rand_ready = 1'b1;
    clear_mon();
    pulse_start(24, 20);
    wait_done("rand", 5000);
    rand_ready = 1'b0;
    #1;
    kp_ready = 1'b1;
    check_raster("rand");
    chk("rand_rd_window", rd_bad, 0);
    chk("rand_reads", rd_cnt, 18 * 14);
    chk("rand_stable", stab_bad, 0);

    // asynchronous reset in the middle of a scan
    fill_map(1);
    clear_mon();
    pulse_start(10, 10);
    cycles(6);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_flags", int'({busy, done, ren_fast, kp_valid}), 0);
    chk("mid_rst_kp_count", int'(kp_count), 0);
    chk("mid_rst_coords", int'(kp_x | x_addr_fast) + int'(kp_y | y_addr_fast), 0);
    clear_mon();
    cycles(3);
    n_rst = 1'b1;
    cycles(5);
    chk("mid_rst_no_done", done_cnt, 0);
    fill_map(0);
    map[3][3] = 1'b1;
    map[5][5] = 1'b1;
    clear_mon();
    pulse_start(10, 10);
    wait_done("rescan", 200);
    chk("rescan_first_addr", first_rx * 100 + first_ry, 303);
    check_raster("rescan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
